j_carry_lookahead_adder: RTL and testbench
==========================================

J_CARRY_LOOKAHEAD_ADDER -- requirements
Module: j_carry_lookahead_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand/sum width; SHALL be a positive multiple of 4 and elaboration SHALL fail otherwise.
REQ-002 Port order SHALL be: clk, rst_n, Y, carryout, A, B, carryin, in_valid, out_valid, group_p, group_g.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 Y  output  WIDTH  registered sum bits.
REQ-006 carryout  output  1  registered carry out of the MSB.
REQ-007 A  input  WIDTH  addend.
REQ-008 B  input  WIDTH  addend.
REQ-009 carryin  input  1  carry into the LSB.
REQ-010 in_valid  input  1  qualifies A/B/carryin in the current cycle.
REQ-011 out_valid  output  1  high when Y/carryout hold a result.
REQ-012 group_p  output  1  registered whole-word propagate, the AND of all (A[i] XOR B[i]).
REQ-013 group_g  output  1  registered whole-word generate, the carry out the word produces with carryin=0.

Function
REQ-014 Bit level: p[i] = A[i] XOR B[i] and g[i] = A[i] AND B[i].
REQ-015 Carries SHALL be computed by 4-bit lookahead blocks, using c[i+1] = g[i] | p[i]&c[i] expanded into two-level sum-of-products within each block, with no ripple inside a block.
REQ-016 Each 4-bit block SHALL produce a block P and a block G, and a second lookahead level SHALL compute the block carry-ins from carryin and the block P/G, so that no ripple occurs between blocks.
REQ-017 Sum: S[i] = p[i] XOR c[i], with c[0] = carryin.
REQ-018 {carryout, Y} SHALL equal A + B + carryin, computed mod 2^(WIDTH+1), with no saturation.
REQ-019 Latency: when in_valid=1 at edge k, Y, carryout, group_p and group_g SHALL show the result of the inputs sampled at edge k, valid after edge k.
REQ-020 out_valid SHALL equal in_valid registered (latency 1).
REQ-021 When in_valid=0 at an edge, Y, carryout, group_p and group_g SHALL hold their previous values.
REQ-022 Throughput: one operation per cycle, with back-to-back in_valid fully supported and no stall or backpressure.
REQ-023 Boundary: all-ones + all-ones + 1 SHALL give Y = all-ones and carryout=1; 0+0+0 SHALL give Y=0 and carryout=0.
REQ-024 Boundary: A + B = all-ones (every p[i]=1) with carryin=1 SHALL give Y=0, carryout=1, group_p=1, group_g=0.
REQ-025 No combinational path from any input to any output is permitted.

Reset
REQ-026 When rst_n=0 at a rising edge, Y, carryout, out_valid, group_p and group_g SHALL all become 0, regardless of in_valid.
REQ-027 Reset SHALL take priority over in_valid in the same cycle, and an operation presented during that cycle SHALL be discarded.
REQ-028 Reset SHALL have no asynchronous effect: outputs change only at a clock edge.
REQ-029 After rst_n returns to 1, the first in_valid=1 edge SHALL produce a correct result with out_valid=1 one cycle later.

Verification (WIDTH=4, one operation per cycle, in_valid=1 unless noted)
REQ-030 A=0, B=0, carryin=0 -> Y=0, carryout=0, group_p=0, group_g=0, out_valid=1 next cycle.
REQ-031 A=3, B=2, carryin=1 -> Y=6, carryout=0.
REQ-032 A=7, B=10, carryin=0 -> Y=1, carryout=1 (sum 17), group_p=0, group_g=1.
REQ-033 A=15, B=15, carryin=1 -> Y=15, carryout=1 (sum 31).
REQ-034 A=5, B=10, carryin=1 -> Y=0, carryout=1, group_p=1; then in_valid=0 with A=1, B=1 -> outputs unchanged and out_valid=0.
REQ-035 Reset mid-stream: drive rst_n=0 in the same cycle as in_valid=1 with A=9, B=9 -> all outputs 0 next cycle; release reset, send A=9, B=9, carryin=0 -> Y=2, carryout=1.
REQ-036 The bench SHALL also run random stimulus at WIDTH=4 and WIDTH=8, comparing {carryout, Y} against A+B+carryin every cycle.

Source files
------------

// File: rtl/j_carry_lookahead_adder.sv
`default_nettype none
// ============================================================================
// Module      : j_carry_lookahead_adder
// Description : Registered two-level carry-lookahead adder. Operands are split
//               into 4-bit lookahead blocks; a second lookahead level derives
//               every block carry-in directly from carryin and the block P/G,
//               so no carry ripples inside or between blocks. Outputs are
//               loaded when in_valid is high and hold otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module j_carry_lookahead_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] Y,
   output logic             carryout,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carryin,
   input  logic             in_valid,
   output logic             out_valid,
   output logic             group_p,
   output logic             group_g
);

   // Kept at least 1 so the declarations below stay legal while the width
   // check reports the real problem.
   localparam int NBLK = (WIDTH < 4) ? 1 : (WIDTH / 4);

   generate
      if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
         $error("j_carry_lookahead_adder: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   logic [WIDTH-1:0] w_p;        // bit propagate
   logic [WIDTH-1:0] w_g;        // bit generate
   logic [WIDTH-1:0] w_c;        // carry into each bit
   logic [WIDTH-1:0] w_sum;
   logic [NBLK-1:0]  w_blk_p;    // block propagate
   logic [NBLK-1:0]  w_blk_g;    // block generate
   logic [NBLK:0]    w_blk_c;    // carry into each block (index NBLK = carry out)
   logic [NBLK:0]    w_gen_c;    // same carries assuming carryin = 0

   logic [WIDTH-1:0] y_q, y_d;
   logic             carryout_q, carryout_d;
   logic             out_valid_q, out_valid_d;
   logic             group_p_q, group_p_d;
   logic             group_g_q, group_g_d;

   assign w_p = A ^ B;
   assign w_g = A & B;

   // First lookahead level: flat sum-of-products carries inside each block.
   generate
      for (genvar b = 0; b < NBLK; b++) begin : g_blk
         localparam int L = 4 * b;
         logic [3:0] w_bp;
         logic [3:0] w_bg;
         logic       w_ci;

         assign w_bp = w_p[L+3:L];
         assign w_bg = w_g[L+3:L];
         assign w_ci = w_blk_c[b];

         assign w_c[L]   = w_ci;
         assign w_c[L+1] = w_bg[0] | (w_bp[0] & w_ci);
         assign w_c[L+2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & w_ci);
         assign w_c[L+3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                         | (w_bp[2] & w_bp[1] & w_bp[0] & w_ci);

         assign w_blk_p[b] = &w_bp;
         assign w_blk_g[b] = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
                           | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
      end
   endgenerate

   // Second lookahead level: each block carry-in as an OR of product terms
   // over the block P/G, with a separate carryin = 0 version for group_g.
   always_comb begin
      logic w_term;
      w_term  = 1'b0;
      w_gen_c = '0;
      w_blk_c = '0;
      for (int j = 0; j <= NBLK; j++) begin
         for (int k = 0; k < j; k++) begin
            w_term = w_blk_g[k];
            for (int m = k + 1; m < j; m++) begin
               w_term = w_term & w_blk_p[m];
            end
            w_gen_c[j] = w_gen_c[j] | w_term;
         end
         w_term = carryin;
         for (int m = 0; m < j; m++) begin
            w_term = w_term & w_blk_p[m];
         end
         w_blk_c[j] = w_gen_c[j] | w_term;
      end
   end

   assign w_sum = w_p ^ w_c;

   // Next-state: load a new result on in_valid, otherwise hold.
   always_comb begin
      out_valid_d = in_valid;
      y_d         = y_q;
      carryout_d  = carryout_q;
      group_p_d   = group_p_q;
      group_g_d   = group_g_q;
      if (in_valid) begin
         y_d        = w_sum;
         carryout_d = w_blk_c[NBLK];
         group_p_d  = &w_p;
         group_g_d  = w_gen_c[NBLK];
      end
   end

   // Output registers; synchronous reset wins over any operation that cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q         <= '0;
         carryout_q  <= 1'b0;
         out_valid_q <= 1'b0;
         group_p_q   <= 1'b0;
         group_g_q   <= 1'b0;
      end else begin
         y_q         <= y_d;
         carryout_q  <= carryout_d;
         out_valid_q <= out_valid_d;
         group_p_q   <= group_p_d;
         group_g_q   <= group_g_d;
      end
   end

   assign Y         = y_q;
   assign carryout  = carryout_q;
   assign out_valid = out_valid_q;
   assign group_p   = group_p_q;
   assign group_g   = group_g_q;

endmodule
`default_nettype wire

// File: tb/tb_j_carry_lookahead_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_j_carry_lookahead_adder
// Description : Self-checking bench for j_carry_lookahead_adder at WIDTH=4
//               and WIDTH=8, using a queue-based scoreboard of expected
//               registered output state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_j_carry_lookahead_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [3:0] a4, b4, y4;
   logic       cin4, iv4, co4, ov4, gp4, gg4;
   logic [7:0] a8, b8, y8;
   logic       cin8, iv8, co8, ov8, gp8, gg8;

   j_carry_lookahead_adder #(.WIDTH(4)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .Y        (y4),
      .carryout (co4),
      .A        (a4),
      .B        (b4),
      .carryin  (cin4),
      .in_valid (iv4),
      .out_valid(ov4),
      .group_p  (gp4),
      .group_g  (gg4)
   );

   j_carry_lookahead_adder #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .Y        (y8),
      .carryout (co8),
      .A        (a8),
      .B        (b8),
      .carryin  (cin8),
      .in_valid (iv8),
      .out_valid(ov8),
      .group_p  (gp8),
      .group_g  (gg8)
   );

   // Expected registered state after an edge: out_valid, {carryout,Y}, P, G.
   typedef struct packed {
      logic       v;
      logic [8:0] sum;
      logic       gp;
      logic       gg;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   exp_t st4, st8;
   exp_t e4, e8;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Drive the 4-bit DUT and push the state it should hold after the next edge.
   task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic iv);
      logic [4:0] s, s0;
      a4 = a; b4 = b; cin4 = cin; iv4 = iv;
      s  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      s0 = {1'b0, a} + {1'b0, b};
      if (!rst_n) begin
         st4 = '0;
      end else begin
         st4.v = iv;
         if (iv) begin
            st4.sum = {4'b0, s};
            st4.gp  = &(a ^ b);
            st4.gg  = s0[4];
         end
      end
      q4.push_back(st4);
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic iv);
      logic [8:0] s, s0;
      a8 = a; b8 = b; cin8 = cin; iv8 = iv;
      s  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      s0 = {1'b0, a} + {1'b0, b};
      if (!rst_n) begin
         st8 = '0;
      end else begin
         st8.v = iv;
         if (iv) begin
            st8.sum = s;
            st8.gp  = &(a ^ b);
            st8.gg  = s0[8];
         end
      end
      q8.push_back(st8);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a4 = 4'd9;   b4 = 4'd9;   cin4 = 1'b1; iv4 = 1'b1;
      a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1; iv8 = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({ov4, co4, y4, gp4, gg4} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_w4: got ov=%0b co=%0b y=%0d gp=%0b gg=%0b, want all 0", ov4, co4, y4, gp4, gg4);
      end
      n_checks++;
      if ({ov8, co8, y8, gp8, gg8} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_w8: got ov=%0b co=%0b y=%0d gp=%0b gg=%0b, want all 0", ov8, co8, y8, gp8, gg8);
      end
      rst_n = 1'b1;
      iv4 = 1'b0; iv8 = 1'b0;
      st4 = '0; st8 = '0;
      q4.delete(); q8.delete();
   endtask

   // Spec vectors plus extras, presented on consecutive cycles.
   task automatic test_back_to_back();
      logic [8:0] vec [0:6];
      vec[0] = {4'd0,  4'd0,  1'b0};
      vec[1] = {4'd3,  4'd2,  1'b1};
      vec[2] = {4'd7,  4'd10, 1'b0};
      vec[3] = {4'd15, 4'd15, 1'b1};
      vec[4] = {4'd8,  4'd7,  1'b0};
      vec[5] = {4'd1,  4'd14, 1'b1};
      vec[6] = {4'd12, 4'd6,  1'b0};
      for (int i = 0; i <= 7; i++) begin
         @(negedge clk);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            n_checks++;
            if ({ov4, co4, y4, gp4, gg4} !== {e4.v, e4.sum[4:0], e4.gp, e4.gg}) begin
               n_fail++;
               $display("FAIL b2b_%0d: got ov=%0b sum=%0d gp=%0b gg=%0b, want ov=%0b sum=%0d gp=%0b gg=%0b",
                        i, ov4, {co4, y4}, gp4, gg4, e4.v, e4.sum[4:0], e4.gp, e4.gg);
            end
         end
         if (i < 7) drive4(vec[i][8:5], vec[i][4:1], vec[i][0], 1'b1);
         else       drive4(4'd0, 4'd0, 1'b0, 1'b0);
      end
      @(negedge clk);
      e4 = q4.pop_front();
      n_checks++;
      if ({ov4, co4, y4, gp4, gg4} !== {e4.v, e4.sum[4:0], e4.gp, e4.gg}) begin
         n_fail++;
         $display("FAIL b2b_idle: got ov=%0b sum=%0d, want ov=%0b sum=%0d", ov4, {co4, y4}, e4.v, e4.sum[4:0]);
      end
   endtask

   // All-propagate boundary, then idle cycles that must hold the result.
   task automatic test_hold();
      @(negedge clk);
      drive4(4'd5, 4'd10, 1'b1, 1'b1);
      @(negedge clk);
      e4 = q4.pop_front();
      n_checks++;
      if ({ov4, co4, y4, gp4, gg4} !== {e4.v, e4.sum[4:0], e4.gp, e4.gg}) begin
         n_fail++;
         $display("FAIL all_prop: got ov=%0b sum=%0d gp=%0b gg=%0b, want ov=%0b sum=%0d gp=%0b gg=%0b",
                  ov4, {co4, y4}, gp4, gg4, e4.v, e4.sum[4:0], e4.gp, e4.gg);
      end
      drive4(4'd1, 4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         e4 = q4.pop_front();
         n_checks++;
         if ({ov4, co4, y4, gp4, gg4} !== {e4.v, e4.sum[4:0], e4.gp, e4.gg}) begin
            n_fail++;
            $display("FAIL hold_%0d: got ov=%0b sum=%0d gp=%0b gg=%0b, want ov=%0b sum=%0d gp=%0b gg=%0b",
                     i, ov4, {co4, y4}, gp4, gg4, e4.v, e4.sum[4:0], e4.gp, e4.gg);
         end
         drive4(4'd3, 4'd4, 1'b1, 1'b0);
      end
      @(negedge clk);
      void'(q4.pop_front());
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      drive4(4'd7, 4'd10, 1'b0, 1'b1);
      @(negedge clk);
      e4 = q4.pop_front();
      n_checks++;
      if ({ov4, co4, y4, gp4, gg4} !== {e4.v, e4.sum[4:0], e4.gp, e4.gg}) begin
         n_fail++;
         $display("FAIL pre_reset: got ov=%0b sum=%0d gp=%0b gg=%0b, want ov=%0b sum=%0d gp=%0b gg=%0b",
                  ov4, {co4, y4}, gp4, gg4, e4.v, e4.sum[4:0], e4.gp, e4.gg);
      end
      rst_n = 1'b0;
      drive4(4'd9, 4'd9, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({ov4, co4, y4} !== {1'b1, 5'd17}) begin
         n_fail++;
         $display("FAIL reset_async: got ov=%0b sum=%0d, want ov=1 sum=17", ov4, {co4, y4});
      end
      @(negedge clk);
      e4 = q4.pop_front();
      n_checks++;
      if ({ov4, co4, y4, gp4, gg4} !== {e4.v, e4.sum[4:0], e4.gp, e4.gg}) begin
         n_fail++;
         $display("FAIL reset_mid: got ov=%0b sum=%0d gp=%0b gg=%0b, want ov=%0b sum=%0d gp=%0b gg=%0b",
                  ov4, {co4, y4}, gp4, gg4, e4.v, e4.sum[4:0], e4.gp, e4.gg);
      end
      rst_n = 1'b1;
      drive4(4'd9, 4'd9, 1'b0, 1'b1);
      @(negedge clk);
      e4 = q4.pop_front();
      n_checks++;
      if ({ov4, co4, y4} !== {e4.v, e4.sum[4:0]} || {co4, y4} !== 5'd18) begin
         n_fail++;
         $display("FAIL post_reset: got ov=%0b sum=%0d, want ov=1 sum=18", ov4, {co4, y4});
      end
      drive4(4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      void'(q4.pop_front());
   endtask

   // Random traffic with random bubbles on both widths, checked every cycle.
   task automatic test_random(input int cycles);
      for (int i = 0; i <= cycles; i++) begin
         @(negedge clk);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            n_checks++;
            if ({ov4, co4, y4, gp4, gg4} !== {e4.v, e4.sum[4:0], e4.gp, e4.gg}) begin
               n_fail++;
               $display("FAIL rand_w4 cyc %0d: got ov=%0b sum=%0d gp=%0b gg=%0b, want ov=%0b sum=%0d gp=%0b gg=%0b",
                        i, ov4, {co4, y4}, gp4, gg4, e4.v, e4.sum[4:0], e4.gp, e4.gg);
            end
         end
         if (q8.size() != 0) begin
            e8 = q8.pop_front();
            n_checks++;
            if ({ov8, co8, y8, gp8, gg8} !== {e8.v, e8.sum, e8.gp, e8.gg}) begin
               n_fail++;
               $display("FAIL rand_w8 cyc %0d: got ov=%0b sum=%0d gp=%0b gg=%0b, want ov=%0b sum=%0d gp=%0b gg=%0b",
                        i, ov8, {co8, y8}, gp8, gg8, e8.v, e8.sum, e8.gp, e8.gg);
            end
         end
         if (i < cycles) begin
            drive4(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
            drive8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
         end
      end
      iv4 = 1'b0;
      iv8 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a4 = '0; b4 = '0; cin4 = 1'b0; iv4 = 1'b0;
      a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0;
      st4 = '0; st8 = '0;
      test_reset();
      test_back_to_back();
      test_hold();
      test_reset_midstream();
      st8 = '0;
      q8.delete();
      test_random(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
